// File: rtl/conv3x3_stream.sv
// ---------------------------------------------------------------------------
// conv3x3_stream
// Streaming 3x3 convolution over one IMG_W x IMG_H raster-order frame. Two
// line buffers and a 3x3 window register build each neighbourhood. Every
// interior window produces one result. The result is the sum of nine signed
// products, arithmetic-shifted right by FRAC, minus bias, saturated to DATA_W
// and optionally passed through ReLU.
//
// Ports:
//   clk, rst_n            rising-edge clock, asynchronous active-low reset
//   kernel[8:0]           coefficients, k = 3*dr + dc (dr=0 oldest row)
//   bias, relu_en         post-scale bias and ReLU enable
//   in_valid/in_ready     pixel handshake, in_pixel raster order
//   out_valid/out_ready   result handshake, out_pixel/out_last
//   frame_done            one-cycle pulse after the out_last beat is consumed
//
// kernel, bias and relu_en are sampled when the first pixel of a frame is
// accepted.
// ---------------------------------------------------------------------------
module conv3x3_stream #(
   parameter int DATA_W = 16,
   parameter int FRAC   = 8,
   parameter int IMG_W  = 6,
   parameter int IMG_H  = 6
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [8:0][DATA_W-1:0] kernel,
   input  logic [DATA_W-1:0]      bias,
   input  logic                   relu_en,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [DATA_W-1:0]      in_pixel,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [DATA_W-1:0]      out_pixel,
   output logic                   out_last,
   output logic                   frame_done
);

   localparam int PROD_W = 2 * DATA_W;
   localparam int ACC_W  = 2 * DATA_W + 4;
   localparam int COL_W  = $clog2(IMG_W);
   localparam int ROW_W  = $clog2(IMG_H);

   localparam logic signed [ACC_W-1:0] SAT_MAX =
      {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
   localparam logic signed [ACC_W-1:0] SAT_MIN =
      {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

   logic advance;
   logic accept;

   logic [COL_W-1:0] col_reg;
   logic [ROW_W-1:0] row_reg;

   logic signed [DATA_W-1:0] lb0_mem [IMG_W];   // previous row
   logic signed [DATA_W-1:0] lb1_mem [IMG_W];   // row before that
   logic signed [DATA_W-1:0] lb0_rd;
   logic signed [DATA_W-1:0] lb1_rd;

   logic signed [DATA_W-1:0] win_reg [3][3];    // [dr][dc], dc=2 newest
   logic                     win_valid_reg;
   logic                     win_last_reg;

   logic signed [DATA_W-1:0] kernel_sh [9];
   logic signed [DATA_W-1:0] bias_sh;
   logic                     relu_sh;

   logic signed [PROD_W-1:0] prod_comb [9];
   logic signed [PROD_W-1:0] prod_reg  [9];
   logic                     prod_valid_reg;
   logic                     prod_last_reg;
   logic signed [DATA_W-1:0] prod_bias_reg;
   logic                     prod_relu_reg;

   logic signed [ACC_W-1:0]  acc_comb;
   logic signed [ACC_W-1:0]  scaled_comb;
   logic signed [ACC_W-1:0]  biased_comb;
   logic [DATA_W-1:0]        res_comb;

   logic first_pix;
   logic win_ok;
   logic win_end;

   // The whole pipeline moves as one unit; a held output freezes everything.
   assign advance  = !out_valid || out_ready;
   assign in_ready = advance;
   assign accept   = in_valid && advance;

   assign first_pix = (col_reg == '0) && (row_reg == '0);
   assign win_ok    = (row_reg >= ROW_W'(2)) && (col_reg >= COL_W'(2));
   assign win_end   = (row_reg == ROW_W'(IMG_H-1)) && (col_reg == COL_W'(IMG_W-1));

   assign lb0_rd = lb0_mem[col_reg];
   assign lb1_rd = lb1_mem[col_reg];

   // Raster position of the next pixel to be accepted.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         col_reg <= '0;
         row_reg <= '0;
      end else if (accept) begin
         if (col_reg == COL_W'(IMG_W-1)) begin
            col_reg <= '0;
            row_reg <= (row_reg == ROW_W'(IMG_H-1)) ? '0 : row_reg + 1'b1;
         end else begin
            col_reg <= col_reg + 1'b1;
         end
      end
   end

   // Line buffers and window. The new window column is {row-2, row-1, current}.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < IMG_W; i++) begin
            lb0_mem[i] <= '0;
            lb1_mem[i] <= '0;
         end
         for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 3; c++) begin
               win_reg[r][c] <= '0;
            end
         end
      end else if (accept) begin
         lb1_mem[col_reg] <= lb0_rd;
         lb0_mem[col_reg] <= in_pixel;
         for (int r = 0; r < 3; r++) begin
            win_reg[r][0] <= win_reg[r][1];
            win_reg[r][1] <= win_reg[r][2];
         end
         win_reg[0][2] <= lb1_rd;
         win_reg[1][2] <= lb0_rd;
         win_reg[2][2] <= in_pixel;
      end
   end

   // Window qualifiers. A cycle without an accepted pixel becomes a bubble.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         win_valid_reg <= 1'b0;
         win_last_reg  <= 1'b0;
      end else if (advance) begin
         win_valid_reg <= accept && win_ok;
         win_last_reg  <= accept && win_end;
      end
   end

   // Per-frame parameter shadows.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < 9; k++) begin
            kernel_sh[k] <= '0;
         end
         bias_sh <= '0;
         relu_sh <= 1'b0;
      end else if (accept && first_pix) begin
         for (int k = 0; k < 9; k++) begin
            kernel_sh[k] <= kernel[k];
         end
         bias_sh <= bias;
         relu_sh <= relu_en;
      end
   end

   for (genvar gi = 0; gi < 9; gi++) begin : g_mul
      assign prod_comb[gi] = win_reg[gi/3][gi%3] * kernel_sh[gi];
   end

   // Stage 1: products. bias/relu travel with them because the shadows may
   // already hold the next frame's values when the last windows reach stage 2.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < 9; k++) begin
            prod_reg[k] <= '0;
         end
         prod_valid_reg <= 1'b0;
         prod_last_reg  <= 1'b0;
         prod_bias_reg  <= '0;
         prod_relu_reg  <= 1'b0;
      end else if (advance) begin
         for (int k = 0; k < 9; k++) begin
            prod_reg[k] <= prod_comb[k];
         end
         prod_valid_reg <= win_valid_reg;
         prod_last_reg  <= win_last_reg;
         prod_bias_reg  <= bias_sh;
         prod_relu_reg  <= relu_sh;
      end
   end

   // Sum, scale (floor), bias, saturate, ReLU.
   always_comb begin
      acc_comb = '0;
      for (int k = 0; k < 9; k++) begin
         acc_comb = acc_comb + {{(ACC_W-PROD_W){prod_reg[k][PROD_W-1]}}, prod_reg[k]};
      end
      scaled_comb = acc_comb >>> FRAC;
      biased_comb = scaled_comb - {{(ACC_W-DATA_W){prod_bias_reg[DATA_W-1]}}, prod_bias_reg};
      if (biased_comb > SAT_MAX) begin
         res_comb = SAT_MAX[DATA_W-1:0];
      end else if (biased_comb < SAT_MIN) begin
         res_comb = SAT_MIN[DATA_W-1:0];
      end else begin
         res_comb = biased_comb[DATA_W-1:0];
      end
      if (prod_relu_reg && res_comb[DATA_W-1]) begin
         res_comb = '0;
      end
   end

   // Stage 2: output register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         out_last  <= 1'b0;
         out_pixel <= '0;
      end else if (advance) begin
         out_valid <= prod_valid_reg;
         out_last  <= prod_valid_reg && prod_last_reg;
         if (prod_valid_reg) begin
            out_pixel <= res_comb;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         frame_done <= 1'b0;
      end else begin
         frame_done <= out_valid && out_ready && out_last;
      end
   end

endmodule

// File: doc/conv3x3_stream.md
# conv3x3_stream

Streaming, parametrised successor to the fixed 6×6-tile convolution block. It accepts a raster-order pixel stream of one IMG_W×IMG_H frame and buffers two lines internally. It produces one 3×3 convolution result per interior window with fixed-point scaling, bias subtraction, saturation and optional ReLU. Valid/ready handshakes on both sides let it sit between the frame reader and the pooling/activation stages of the accelerator pipeline.

## Interface
- DATA_W, 16: pixel, kernel, bias and result width (signed two's complement)
- FRAC, 8: fractional bits of kernel coefficients; the accumulator is arithmetic-shifted right by FRAC
- IMG_W, 6: pixels per row (≥3)
- IMG_H, 6: rows per frame (≥3)

- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- kernel  in  9×DATA_W  coefficients; index k = 3·dr + dc (dr=0 oldest row, dc=0 leftmost column)
- bias  in  DATA_W  subtracted after scaling
- relu_en  in  1  1 = clamp negative results to 0
- in_valid  in  1  pixel offered
- in_ready  out  1  pixel accepted when in_valid & in_ready
- in_pixel  in  DATA_W  pixel, raster order
- out_valid  out  1  result offered
- out_ready  in  1  result consumed when out_valid & out_ready
- out_pixel  out  DATA_W  result
- out_last  out  1  qualifies the final result of a frame
- frame_done  out  1  one-cycle pulse when the out_last beat is consumed

## Operation
- Counters col (0..IMG_W-1) and row (0..IMG_H-1) advance on each accepted pixel. col wraps to 0 and increments row. After (IMG_W-1, IMG_H-1) both wrap to 0 and a new frame begins.
- Two line buffers of IMG_W×DATA_W plus a 3×3 window register shift on each accepted pixel.
- kernel, bias and relu_en are latched into shadow registers when the first pixel of a frame (row=0, col=0) is accepted. Changes mid-frame have no effect until the next frame.
- A window is valid when the accepted pixel has row≥2 and col≥2. This gives (IMG_W-2)·(IMG_H-2) results per frame in raster order. Non-interior pixels travel the pipeline as bubbles and never assert out_valid.
- Arithmetic:
  - Nine signed DATA_W×DATA_W products are summed into ACC_W = 2·DATA_W+4 bits.
  - The sum is arithmetic-shifted right by FRAC (truncation toward −∞), then bias is subtracted, sign-extended.
  - The result saturates to [−2^(DATA_W-1), 2^(DATA_W-1)-1].
  - If relu_en is latched 1, negative results become 0.
- Pipeline has two stages: S1 registers the window and the nine products; S2 registers the sum, scale, bias, saturate and ReLU result into the output register.
- Backpressure: advance = !out_valid | out_ready. in_ready = advance. All stages and counters move only when advance=1, so no beat is lost or duplicated.
- out_last is set on the result for window (row=IMG_H-1, col=IMG_W-1).

## Timing
- Reset values: in_ready=1 (combinational from out_valid=0), out_valid=0, out_pixel=0, out_last=0, frame_done=0. Counters, line buffers, window, pipeline valids and shadow registers reset to 0.
- Latency: result for the pixel accepted at edge t appears with out_valid=1 after edge t+2 when out_ready stays high.
- Throughput: one pixel per cycle with no stall; one result per cycle across a row interior.
- Stall: while out_valid=1 and out_ready=0:
  - out_pixel and out_last hold.
  - in_ready=0, and in_valid is ignored.
- Simultaneous accept and consume in the same cycle is allowed and sustains full rate.
- An in_valid gap inserts a bubble without corrupting the window.
- Asserting rst_n low mid-frame discards the partial frame immediately. The first pixel after release is treated as (0,0).
- frame_done asserts on the cycle after the out_last handshake edge, for exactly one cycle.

## Test plan
- Identity test:
  - Stimulus: defaults; kernel center=256, others 0; bias=0; relu_en=0; frame pixel = 10·row+col; out_ready=1.
  - Required response: 16 results 11,12,13,14,21,…,44.
  - out_last only on 44; frame_done one cycle later.
- Box sum with bias:
  - Stimulus: all kernel=256, bias=5, all pixels=3.
  - Required response: every result 22.
- Saturation and ReLU:
  - Stimulus: all kernel=256, all pixels=0x7FFF.
  - Required response: all results 0x7FFF.
  - Then pixels=0x8000 with relu_en=1: all results 0.
  - Same pixels with relu_en=0: all results 0x8000.
- Backpressure:
  - Stimulus: the identity test with out_ready toggling by a random 30% duty and in_valid gaps.
  - Required response: the identical 16-value sequence, with out_pixel stable during every stall.
- Mid-frame changes:
  - Stimulus: change kernel after pixel 10.
  - Required response: results use the old kernel; the next frame uses the new one.
- Reset mid-frame:
  - Stimulus: pulse rst_n low after 20 pixels.
  - Required response: outputs go to reset values at once; a following full frame yields the correct 16 results.
